fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the instruction pointer and sequences the fetch datapath (IP increment + IMemory read), presenting one instruction per cycle to decode over a valid/ready handshake.
- Handles downstream stall, branch/jump redirect with squash, and halt/resume.
- Keeps a saturating stall-cycle counter.
- Sits between IMemory (combinational read) and the decode stage.

Parameters:
- ISIZE, 17, instruction width in bits.
- MSIZE, 10, instruction-memory address width in bits.
- RESET_IP, 0, IP value loaded on reset.
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  MSIZE  IMemory read address; combinationally equal to the IP register.
- imem_data  in  ISIZE  IMemory read data; combinational from imem_addr.
- out_valid  out  1  out_instr/out_ip hold a live instruction.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  ISIZE  registered instruction.
- out_ip  out  MSIZE  address out_instr was fetched from.
- redirect_valid  in  1  branch/jump taken; load new IP.
- redirect_target  in  MSIZE  new IP.
- resume  in  1  leave HALT and continue at the current IP.
- halted  out  1  high while in HALT.
- stall_count  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - ip = RESET_IP; out_valid = 0; out_instr = 0; out_ip = 0; state = RUN; stall_count = 0.
  - Reset overrides every other input in the same cycle, including mid-stall and mid-halt.
- Load enable: load = !out_valid || out_ready.
- Priority per cycle: reset > redirect_valid > stall/fetch/halt logic.
- Redirect, any state:
  - ip <= redirect_target; out_valid <= 0; state <= RUN.
  - The instruction presented that cycle is squashed regardless of out_ready; decode must not commit it.
  - Latency: redirect in cycle N, bubble in N+1, out_valid=1 with out_ip=target in N+2.
- RUN, load=1:
  - out_instr <= imem_data; out_ip <= ip; out_valid <= 1; ip <= ip+1, wrapping modulo 2^MSIZE (1023 -> 0).
  - If the opcode field of imem_data equals OPC_HALT: state <= HALT. The halt instruction itself is delivered. ip still advances past it.
- RUN, load=0 (stall): ip, out_* and state hold.
- HALT:
  - No new fetch; ip holds.
  - The output register drains normally: out_valid <= 0 on handshake, otherwise holds.
  - resume=1: state <= RUN, no fetch that cycle, fetch resumes the next cycle at ip.
  - resume while in RUN is ignored.
  - redirect and resume in the same cycle: redirect wins.
- halted = (state == HALT), registered state decode.
- stall_count increments each cycle out_valid && !out_ready, including in HALT and including redirect cycles. It holds at 2^CNT_W-1 and clears only on reset.
- Throughput: 1 instruction/cycle with out_ready held high; no bubbles except after redirect/resume.

Decomposition:
- Shared package fetch_pkg:
  - ISIZE/MSIZE defaults.
  - OPC_MSB=16, OPC_LSB=12 (5-bit opcode field).
  - OPC_HALT = 5'b11111.
  - fetch_state_t enum {RUN, HALT}.
- One natural sub-module: fetch_out_reg (valid/ready pipeline register holding instr+ip, with squash input).
- IP increment and stall counter stay inline.

Test Plan:
- Reset, imem holds addr-tagged NOPs, out_ready=1 -> out_ip 0,1,2,3 on consecutive cycles from cycle 1 after reset release, out_valid continuous.
- out_ready=0 for 3 cycles while out_ip=5 -> out_ip/out_instr/imem_addr frozen at 5/6, stall_count=3; release -> out_ip 6 next cycle.
- redirect_valid with target=0x200 while out_ip=7, out_ready=1 -> next cycle out_valid=0; following cycle out_ip=0x200; instruction 7 squashed.
- HALT opcode at addr 4 -> out_ip=4 delivered, halted=1, no further fetch; resume -> halted=0, then out_ip=5 one cycle later.
- Start from redirect target 1022 -> out_ip 1022, 1023, 0 (wrap).
- reset asserted together with redirect_valid mid-stall -> next cycle ip=RESET_IP, out_valid=0, stall_count=0, halted=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, opcode field location and FSM state type.
package fetch_pkg;
  localparam int ISIZE_DEFAULT = 17;
  localparam int MSIZE_DEFAULT = 10;
  localparam int OPC_MSB = 16;
  localparam int OPC_LSB = 12;
  localparam logic [4:0] OPC_HALT = 5'b11111;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;

  function automatic logic is_halt(input logic [4:0] opc);
    return opc == OPC_HALT;
  endfunction
endpackage

// File: rtl/fetch_out_reg.sv
// Output pipeline register holding the fetched instruction and its address for decode.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int ISIZE = ISIZE_DEFAULT,
  parameter int MSIZE = MSIZE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch,
  input  logic             squash,
  input  logic             ready,
  input  logic [ISIZE-1:0] in_instr,
  input  logic [MSIZE-1:0] in_ip,
  output logic             valid,
  output logic [ISIZE-1:0] instr,
  output logic [MSIZE-1:0] ip
);
  // Squash only drops valid; payload is don't-care while valid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      ip    <= '0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (fetch) begin
      valid <= 1'b1;
      instr <= in_instr;
      ip    <= in_ip;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction pointer owner and fetch sequencer: one instruction per cycle to decode,
// with stall, redirect/squash, halt/resume and a saturating stall-cycle counter.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               ISIZE    = ISIZE_DEFAULT,
  parameter int               MSIZE    = MSIZE_DEFAULT,
  parameter logic [MSIZE-1:0] RESET_IP = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [MSIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ISIZE-1:0] out_instr,
  output logic [MSIZE-1:0] out_ip,
  input  logic             redirect_valid,
  input  logic [MSIZE-1:0] redirect_target,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  // Handshake: an instruction transfers on a cycle with out_valid && out_ready; while
  // out_valid is high and out_ready is low, out_instr/out_ip hold stable.
  fetch_state_t     state;
  logic [MSIZE-1:0] ip;
  logic             load;
  logic             fetch;

  assign load      = !out_valid || out_ready;
  assign fetch     = !redirect_valid && (state == RUN) && load;
  assign imem_addr = ip;
  assign halted    = (state == HALT);

  always_ff @(posedge clock) begin
    if (reset) begin
      ip          <= RESET_IP;
      state       <= RUN;
      stall_count <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (redirect_valid) begin
        ip    <= redirect_target;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (load) begin
              ip <= ip + MSIZE'(1);
              if (is_halt(imem_data[OPC_MSB:OPC_LSB])) state <= HALT;
            end
          end
          HALT: begin
            // Resume only re-arms; the next fetch happens on the following cycle.
            if (resume) state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  fetch_out_reg #(
    .ISIZE(ISIZE),
    .MSIZE(MSIZE)
  ) u_out_reg (
    .clock   (clock),
    .reset   (reset),
    .fetch   (fetch),
    .squash  (redirect_valid),
    .ready   (out_ready),
    .in_instr(imem_data),
    .in_ip   (ip),
    .valid   (out_valid),
    .instr   (out_instr),
    .ip      (out_ip)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a cycle reference model and an expected-delivery queue.
module tb_fetch_sequencer;
  localparam int ISIZE = 17;
  localparam int MSIZE = 10;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [MSIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_data;
  logic             out_valid;
  logic             out_ready;
  logic [ISIZE-1:0] out_instr;
  logic [MSIZE-1:0] out_ip;
  logic             redirect_valid;
  logic [MSIZE-1:0] redirect_target;
  logic             resume;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  logic [ISIZE-1:0] mem [0:1023];
  assign imem_data = mem[imem_addr];

  always #5 clock = ~clock;

  fetch_sequencer #(.ISIZE(ISIZE), .MSIZE(MSIZE), .RESET_IP('0), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_ip(out_ip),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .resume(resume),
    .halted(halted), .stall_count(stall_count)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state, kept as plain integers.
  int m_ip, m_instr, m_oip, m_stall;
  bit m_valid, m_halt;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_nops();
    for (int a = 0; a < 1024; a++) mem[a] = ISIZE'(a);
  endtask

  // Advance one clock: compute the model's next state from the current inputs,
  // score any instruction leaving the output register, then compare.
  task automatic cycle();
    int n_ip, n_instr, n_oip, n_stall;
    bit n_valid, n_halt;
    logic [31:0] front;
    n_ip = m_ip; n_instr = m_instr; n_oip = m_oip; n_stall = m_stall;
    n_valid = m_valid; n_halt = m_halt;
    if (reset) begin
      n_ip = 0; n_instr = 0; n_oip = 0; n_stall = 0; n_valid = 0; n_halt = 0;
      exp_q.delete();
    end else begin
      if (m_valid && !out_ready && m_stall < (1 << CNT_W) - 1) n_stall = m_stall + 1;
      if (m_valid && (out_ready || redirect_valid) && exp_q.size() > 0) begin
        front = exp_q.pop_front();
        if (!redirect_valid) chk("deliver", {5'd0, out_ip, out_instr}, front);
      end
      if (redirect_valid) begin
        n_ip = int'(redirect_target); n_valid = 0; n_halt = 0;
      end else if (!m_halt) begin
        if (!m_valid || out_ready) begin
          n_instr = int'(mem[m_ip]); n_oip = m_ip; n_valid = 1;
          n_ip = (m_ip + 1) % 1024;
          if ((n_instr >> 12) == 31) n_halt = 1;
          exp_q.push_back({5'd0, 10'(n_oip), 17'(n_instr)});
        end
      end else begin
        if (out_ready) n_valid = 0;
        if (resume) n_halt = 0;
      end
    end
    @(posedge clock);
    #1;
    m_ip = n_ip; m_instr = n_instr; m_oip = n_oip; m_stall = n_stall;
    m_valid = n_valid; m_halt = n_halt;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("imem_addr", 32'(imem_addr), 32'(m_ip));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    if (m_valid) begin
      chk("out_ip", 32'(out_ip), 32'(m_oip));
      chk("out_instr", 32'(out_instr), 32'(m_instr));
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0; resume = 1'b0;
    m_ip = 0; m_instr = 0; m_oip = 0; m_stall = 0; m_valid = 0; m_halt = 0;
    fill_nops();

    // Reset state and streaming from RESET_IP.
    cycle(); cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ip", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("stream_ip", 32'(out_ip), 32'(i));
      chk("stream_valid", 32'(out_valid), 32'd1);
    end

    // Stall for 3 cycles at out_ip=5.
    out_ready = 1'b0;
    cycle(); cycle(); cycle();
    chk("stall_ip", 32'(out_ip), 32'd5);
    chk("stall_instr", 32'(out_instr), 32'd5);
    chk("stall_addr", 32'(imem_addr), 32'd6);
    chk("stall_cnt", 32'(stall_count), 32'd3);
    out_ready = 1'b1;
    cycle(); chk("release_ip", 32'(out_ip), 32'd6);
    cycle(); chk("pre_redir_ip", 32'(out_ip), 32'd7);

    // Redirect to 0x200 squashes instruction 7.
    redirect_valid = 1'b1; redirect_target = 10'h200;
    cycle();
    chk("redir_bubble", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    chk("redir_ip", 32'(out_ip), 32'h200);
    chk("redir_valid", 32'(out_valid), 32'd1);

    // HALT opcode at address 4, then resume.
    mem[4] = {5'b11111, 12'd4};
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("halt_ip", 32'(out_ip), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    cycle(); cycle();
    chk("halt_drain", 32'(out_valid), 32'd0);
    chk("halt_hold_ip", 32'(imem_addr), 32'd5);
    resume = 1'b1; cycle(); resume = 1'b0;
    chk("resume_flag", 32'(halted), 32'd0);
    chk("resume_bubble", 32'(out_valid), 32'd0);
    cycle();
    chk("resume_ip", 32'(out_ip), 32'd5);
    fill_nops();

    // Address wrap 1022 -> 1023 -> 0.
    redirect_valid = 1'b1; redirect_target = 10'd1022; cycle(); redirect_valid = 1'b0;
    cycle(); chk("wrap_a", 32'(out_ip), 32'd1022);
    cycle(); chk("wrap_b", 32'(out_ip), 32'd1023);
    cycle(); chk("wrap_c", 32'(out_ip), 32'd0);

    // Reset together with redirect in the middle of a stall.
    out_ready = 1'b0; cycle(); cycle();
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 10'h55;
    cycle();
    chk("rstredir_ip", 32'(imem_addr), 32'd0);
    chk("rstredir_valid", 32'(out_valid), 32'd0);
    chk("rstredir_stall", 32'(stall_count), 32'd0);
    chk("rstredir_halt", 32'(halted), 32'd0);
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int a = 0; a < 1024; a++)
      mem[a] = ($urandom_range(0, 9) == 0) ? {5'b11111, 12'($urandom)} : 17'($urandom);
    for (int i = 0; i < 3000; i++) begin
      out_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 10'($urandom);
      resume          = ($urandom_range(0, 4) == 0);
      reset           = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
